fpga_intc: RTL and testbench
============================

FPGA_INTC -- requirements
Module: fpga_intc

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 7, number of external interrupt sources (1..7); source i maps to IPL level i+1.
REQ-002 SHALL provide parameter VEC_BASE, default 8'h40, base of the returned interrupt vector.
REQ-003 SHALL have ports: clk  in  1  single system clock, all logic rising-edge.
REQ-004 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have: fpga_stb  in  1  register access strobe; fpga_we  in  1  write when 1; fpga_ack  out  1  one-cycle access acknowledge.
REQ-006 SHALL have: fpga_addr  in  4  register select; fpga_data  in  8  write data; fpga_odata  out  32  read data.
REQ-007 SHALL have: irq_in  in  NUM_SRC  active-high interrupt requests, synchronous to clk.
REQ-008 SHALL have: iack_stb  in  1  CPU interrupt-acknowledge strobe; iack_level  in  3  acknowledged level; iack_ack  out  1  one-cycle pulse; iack_vec  out  8  vector.
REQ-009 SHALL have: out_ipl  out  3  active-low 68040 IPL encoding.

Function
REQ-010 Register map SHALL be: 0x0 PENDING (R, write-1-to-clear), 0x4 MASK (RW), 0x8 SWINT (RW, bits[2:0]), 0xC STATUS (R: [2:0] current level, [15:8] current vector); other addresses read 0, writes ignored.
REQ-011 Read data SHALL be zero-extended to 32 bits and held valid while fpga_ack is high.
REQ-012 Access FSM SHALL have states IDLE, ACK, WAITLOW: IDLE + stb -> ACK (write performed on that edge); ACK -> WAITLOW (fpga_ack high exactly in ACK); WAITLOW -> IDLE when stb low.
REQ-013 A held stb SHALL produce exactly one access and one ack pulse.
REQ-014 A rising edge on irq_in[i] (0->1 between consecutive cycles) SHALL set PENDING[i] on the next edge.
REQ-015 Same-cycle irq edge set and W1C clear of one bit SHALL resolve to set.
REQ-016 Active level SHALL be max(highest i+1 with PENDING[i]&MASK[i], SWINT), 0 if none.
REQ-017 out_ipl SHALL equal ~level, registered; one cycle after pending/mask/swint change.
REQ-018 iack_stb SHALL produce iack_ack one cycle later with iack_vec = VEC_BASE + iack_level, ignoring held-stb repeats as REQ-013.
REQ-019 iack for level L in 1..NUM_SRC SHALL clear PENDING[L-1]; iack for SWINT level SHALL clear SWINT to 0 when SWINT == L.
REQ-020 iack for a level with no pending source SHALL still ack, vector VEC_BASE (spurious).
REQ-021 Simultaneous iack clear and register W1C SHALL both apply.

Reset
REQ-022 On rst: PENDING=0, MASK=0, SWINT=0, FSMs IDLE, fpga_ack=0, iack_ack=0, iack_vec=0, fpga_odata=0, out_ipl=3'b111, edge history = current 0.
REQ-023 rst asserted mid-access SHALL drop acks immediately; no partial write completes.

Configuration
REQ-024 Macro FPGA_INTC_SWINT_EN defined: SWINT register and its level contribution exist.
REQ-025 Undefined: SWINT reads 0, writes ignored, level from PENDING&MASK only.

Structure
REQ-026 Shared package fpga_intc_pkg SHALL hold register offsets, FSM state encoding and IPL/vector width constants.
REQ-027 Sub-module fpga_intc_prio (pure priority encoder, NUM_SRC-parametrised) SHALL compute level.

Verification
REQ-028 MASK=0x7F, pulse irq_in[2] -> PENDING=0x04, out_ipl=3'b100 two cycles later.
REQ-029 irq_in[0] and [5] pending, MASK=0x7F -> out_ipl=3'b001; MASK=0x01 -> out_ipl=3'b110.
REQ-030 stb held 10 cycles, read 0x0 -> exactly one fpga_ack pulse, odata=PENDING.
REQ-031 iack_level=6 with PENDING[5] set -> iack_ack, iack_vec=8'h46, PENDING[5] cleared.
REQ-032 SWINT=3 (macro on) -> out_ipl=3'b100; macro off -> SWINT reads 0, out_ipl=3'b111.
REQ-033 rst asserted in ACK state -> fpga_ack low same cycle, MASK=0, out_ipl=3'b111.

Source files
------------

// File: rtl/fpga_intc_pkg.sv
// fpga_intc_pkg: register offsets, access FSM encoding and IPL/vector widths
// shared by the interrupt controller and its priority encoder.
package fpga_intc_pkg;
   localparam int IPL_W = 3;
   localparam int VEC_W = 8;
   localparam logic [3:0] A_PENDING = 4'h0;
   localparam logic [3:0] A_MASK    = 4'h4;
   localparam logic [3:0] A_SWINT   = 4'h8;
   localparam logic [3:0] A_STATUS  = 4'hC;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK = 2'd1, ST_WAITLOW = 2'd2} acc_state_e;
endpackage

// File: rtl/fpga_intc_prio.sv
// fpga_intc_prio: level = max(highest i+1 with req_i[i], floor_i), 0 if none.
module fpga_intc_prio import fpga_intc_pkg::*; #(
   parameter int NUM_SRC = 7
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IPL_W-1:0]   floor_i,
   output logic [IPL_W-1:0]   level_o
);
   always_comb begin
      level_o = floor_i;
      for (int i = 0; i < NUM_SRC; i++)
         if (req_i[i] && IPL_W'(i + 1) > level_o) level_o = IPL_W'(i + 1);
   end
endmodule

// File: rtl/fpga_intc.sv
// fpga_intc: 68040-style interrupt controller with edge-latched sources and a register port.
// Define FPGA_INTC_SWINT_EN to include the software interrupt level register.
module fpga_intc import fpga_intc_pkg::*; #(
   parameter int               NUM_SRC  = 7,
   parameter logic [VEC_W-1:0] VEC_BASE = 8'h40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fpga_stb,
   input  logic               fpga_we,
   output logic               fpga_ack,
   input  logic [3:0]         fpga_addr,
   input  logic [7:0]         fpga_data,
   output logic [31:0]        fpga_odata,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               iack_stb,
   input  logic [IPL_W-1:0]   iack_level,
   output logic               iack_ack,
   output logic [VEC_W-1:0]   iack_vec,
   output logic [IPL_W-1:0]   out_ipl
);
   acc_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d, irq_q, rise, w1c, iack_clr;
   logic [NUM_SRC:0]   iack_oh;
   logic               access, wr, iack_seen_q, iack_go, iack_ack_q, iack_hit;
   logic [VEC_W-1:0]   iack_vec_q, cur_vec;
   logic [IPL_W-1:0]   swint, level, out_ipl_q;
   logic [31:0]        odata_q, rdata;
   logic               unused_ok;

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    state_d = fpga_stb ? ST_ACK : ST_IDLE;
         ST_ACK:     state_d = ST_WAITLOW;
         ST_WAITLOW: state_d = fpga_stb ? ST_WAITLOW : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fpga_ack = (state_q == ST_ACK);
      access   = (state_q == ST_IDLE) && fpga_stb;
   end

`ifdef FPGA_INTC_SWINT_EN
   logic [IPL_W-1:0] swint_q;
   always_ff @(posedge clk or posedge rst)
      if (rst)                                                 swint_q <= '0;
      else if (wr && fpga_addr == A_SWINT)                     swint_q <= fpga_data[IPL_W-1:0];
      else if (iack_go && iack_level != 0 && swint_q == iack_level) swint_q <= '0;
   assign swint = swint_q;
`else
   assign swint = '0;
`endif

   fpga_intc_prio #(.NUM_SRC(NUM_SRC)) u_prio (
      .req_i  (pending_q & mask_q),
      .floor_i(swint),
      .level_o(level)
   );

   always_comb begin
      wr        = access && fpga_we;
      rise      = irq_in & ~irq_q;
      w1c       = (wr && fpga_addr == A_PENDING) ? fpga_data[NUM_SRC-1:0] : '0;
      iack_go   = iack_stb && !iack_seen_q;
      iack_oh   = {{NUM_SRC{1'b0}}, 1'b1} << iack_level;
      iack_clr  = iack_go ? iack_oh[NUM_SRC:1] : '0;
      iack_hit  = |(iack_clr & pending_q) || (iack_go && iack_level != 0 && swint == iack_level);
      // a new edge wins over a same-cycle clear of that bit
      pending_d = (pending_q & ~w1c & ~iack_clr) | rise;
      mask_d    = (wr && fpga_addr == A_MASK) ? fpga_data[NUM_SRC-1:0] : mask_q;
      cur_vec   = VEC_BASE + VEC_W'(level);
      rdata     = fpga_addr == A_PENDING ? 32'(pending_q) :
                  fpga_addr == A_MASK    ? 32'(mask_q) :
                  fpga_addr == A_SWINT   ? 32'(swint) :
                  fpga_addr == A_STATUS  ? {16'h0, cur_vec, 5'h0, level} : 32'h0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pending_q   <= '0;
         mask_q      <= '0;
         irq_q       <= '0;
         iack_seen_q <= 1'b0;
         iack_ack_q  <= 1'b0;
         iack_vec_q  <= '0;
         odata_q     <= '0;
         out_ipl_q   <= '1;
      end else begin
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         irq_q       <= irq_in;
         iack_seen_q <= iack_stb;
         iack_ack_q  <= iack_go;
         if (iack_go) iack_vec_q <= iack_hit ? VEC_BASE + VEC_W'(iack_level) : VEC_BASE;
         if (access)  odata_q    <= rdata;
         out_ipl_q   <= ~level;
      end

   assign fpga_odata = odata_q;
   assign iack_ack   = iack_ack_q;
   assign iack_vec   = iack_vec_q;
   assign out_ipl    = out_ipl_q;
   assign unused_ok  = &{1'b0, fpga_data, iack_oh[0]};
endmodule

// File: tb/tb_fpga_intc.sv
// tb_fpga_intc: directed vectors with hand-computed expectations for fpga_intc.
module tb_fpga_intc;
   logic        clk, rst, fpga_stb, fpga_we, fpga_ack, iack_stb, iack_ack;
   logic [3:0]  fpga_addr;
   logic [7:0]  fpga_data, iack_vec;
   logic [31:0] fpga_odata, rd;
   logic [6:0]  irq_in;
   logic [2:0]  iack_level, out_ipl;
   int          checks = 0, errors = 0, acks;

`ifdef FPGA_INTC_SWINT_EN
   localparam logic [31:0] SW_RD = 32'h3, SW_IPL = 32'h4, SW_VEC = 32'h43;
`else
   localparam logic [31:0] SW_RD = 32'h0, SW_IPL = 32'h7, SW_VEC = 32'h40;
`endif

   fpga_intc #(.NUM_SRC(7), .VEC_BASE(8'h40)) dut (
      .clk(clk), .rst(rst), .fpga_stb(fpga_stb), .fpga_we(fpga_we), .fpga_ack(fpga_ack),
      .fpga_addr(fpga_addr), .fpga_data(fpga_data), .fpga_odata(fpga_odata),
      .irq_in(irq_in), .iack_stb(iack_stb), .iack_level(iack_level),
      .iack_ack(iack_ack), .iack_vec(iack_vec), .out_ipl(out_ipl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic acc(input logic we, input logic [3:0] a, input logic [7:0] d, output logic [31:0] r);
      int n = 0;
      fpga_stb = 1'b1; fpga_we = we; fpga_addr = a; fpga_data = d;
      @(negedge clk);
      while (!fpga_ack && n < 5) begin @(negedge clk); n++; end
      chk("acc_ack", {31'h0, fpga_ack}, 32'h1);
      r = fpga_odata;
      fpga_stb = 1'b0;
      tick(2);
   endtask

   task automatic iack(input logic [2:0] l);
      iack_stb = 1'b1; iack_level = l;
      @(negedge clk);
      chk("iack_ack", {31'h0, iack_ack}, 32'h1);
      iack_stb = 1'b0;
      tick(1);
   endtask

   initial begin
      rst = 1'b1; fpga_stb = 0; fpga_we = 0; fpga_addr = 0; fpga_data = 0;
      irq_in = 0; iack_stb = 0; iack_level = 0;
      tick(3);
      rst = 1'b0;
      chk("rst_fpga_ack", {31'h0, fpga_ack}, 32'h0);
      chk("rst_iack_ack", {31'h0, iack_ack}, 32'h0);
      chk("rst_iack_vec", {24'h0, iack_vec}, 32'h0);
      chk("rst_odata", fpga_odata, 32'h0);
      chk("rst_ipl", {29'h0, out_ipl}, 32'h7);
      tick(1);
      acc(0, 4'h0, 0, rd); chk("rst_pending", rd, 32'h0);
      acc(0, 4'h4, 0, rd); chk("rst_mask", rd, 32'h0);
      acc(1, 4'h4, 8'h7F, rd);
      acc(0, 4'h4, 0, rd); chk("mask_rd", rd, 32'h7F);
      // single source pulse: level 3 appears on out_ipl two edges after the pulse
      irq_in = 7'h04; tick(1); irq_in = 7'h00;
      chk("ipl_lag", {29'h0, out_ipl}, 32'h7);
      tick(1);
      chk("ipl_src2", {29'h0, out_ipl}, 32'h4);
      acc(0, 4'h0, 0, rd); chk("pending_src2", rd, 32'h04);
      irq_in = 7'h21; tick(1); irq_in = 7'h00; tick(2);
      chk("ipl_src5", {29'h0, out_ipl}, 32'h1);
      acc(1, 4'h4, 8'h01, rd);
      chk("ipl_mask1", {29'h0, out_ipl}, 32'h6);
      acc(0, 4'hC, 0, rd); chk("status", rd, 32'h0000_4101);
      // held strobe: one access, one ack
      fpga_stb = 1'b1; fpga_we = 1'b0; fpga_addr = 4'h0; acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fpga_ack) begin acks++; rd = fpga_odata; end
      end
      fpga_stb = 1'b0; tick(2);
      chk("held_acks", acks, 32'd1);
      chk("held_odata", rd, 32'h25);
      // iack with held strobe
      iack_stb = 1'b1; iack_level = 3'd6;
      @(negedge clk);
      chk("iack6_ack", {31'h0, iack_ack}, 32'h1);
      chk("iack6_vec", {24'h0, iack_vec}, 32'h46);
      @(negedge clk);
      chk("iack6_held", {31'h0, iack_ack}, 32'h0);
      iack_stb = 1'b0; tick(1);
      acc(0, 4'h0, 0, rd); chk("pending_iack6", rd, 32'h05);
      iack(3'd4); chk("spurious_vec", {24'h0, iack_vec}, 32'h40);
      // edge set and W1C of the same bit on one edge
      fpga_stb = 1'b1; fpga_we = 1'b1; fpga_addr = 4'h0; fpga_data = 8'h02; irq_in = 7'h02;
      tick(1);
      fpga_stb = 1'b0; irq_in = 7'h00; tick(2);
      acc(0, 4'h0, 0, rd); chk("set_wins", rd, 32'h07);
      acc(1, 4'h0, 8'h01, rd);
      acc(0, 4'h0, 0, rd); chk("w1c", rd, 32'h06);
      // iack clear and W1C together
      fpga_stb = 1'b1; fpga_we = 1'b1; fpga_addr = 4'h0; fpga_data = 8'h02;
      iack_stb = 1'b1; iack_level = 3'd3;
      @(negedge clk);
      chk("both_iack", {31'h0, iack_ack}, 32'h1);
      chk("both_vec", {24'h0, iack_vec}, 32'h43);
      fpga_stb = 1'b0; iack_stb = 1'b0; tick(2);
      acc(0, 4'h0, 0, rd); chk("both_clear", rd, 32'h0);
      acc(1, 4'h3, 8'hFF, rd);
      acc(0, 4'h3, 0, rd); chk("unmapped_rd", rd, 32'h0);
      acc(0, 4'h4, 0, rd); chk("unmapped_wr", rd, 32'h01);
      acc(1, 4'h8, 8'h03, rd);
      acc(0, 4'h8, 0, rd); chk("swint_rd", rd, SW_RD);
      chk("swint_ipl", {29'h0, out_ipl}, SW_IPL);
      iack(3'd3); chk("swint_vec", {24'h0, iack_vec}, SW_VEC);
      acc(0, 4'h8, 0, rd); chk("swint_cleared", rd, 32'h0);
      chk("swint_ipl_off", {29'h0, out_ipl}, 32'h7);
      // reset while in ACK
      acc(1, 4'h4, 8'h7F, rd);
      irq_in = 7'h10; tick(1); irq_in = 7'h00; tick(2);
      chk("ipl_src4", {29'h0, out_ipl}, 32'h2);
      fpga_stb = 1'b1; fpga_we = 1'b1; fpga_addr = 4'h4; fpga_data = 8'h55;
      @(negedge clk);
      chk("pre_rst_ack", {31'h0, fpga_ack}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rst_drop_ack", {31'h0, fpga_ack}, 32'h0);
      chk("rst_drop_ipl", {29'h0, out_ipl}, 32'h7);
      fpga_stb = 1'b0;
      @(negedge clk); rst = 1'b0; tick(1);
      acc(0, 4'h4, 0, rd); chk("rst_mid_mask", rd, 32'h0);
      acc(0, 4'h0, 0, rd); chk("rst_mid_pending", rd, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
